// File: rtl/gray_frame_collector.sv
// Single-frame buffer between the gray filter and the first CNN layer.
// Collects IMG_W*IMG_H raster pixels, flags completion, then replays the
// frame over a valid/ready stream when asked.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_px, i_px_valid  incoming gray pixel stream
//   o_in_ready        high while collecting
//   i_clr             synchronous abort back to collecting
//   o_frame_done      one-cycle pulse after the last pixel is stored
//   i_rd_start        start replay (only while a full frame is held)
//   o_rd_px/valid/last, i_rd_ready   replay stream
//   o_overflow        sticky: pixel arrived while not collecting
module gray_frame_collector #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PX_BW = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PX_BW-1:0] i_px,
    input  logic             i_px_valid,
    output logic             o_in_ready,
    input  logic             i_clr,
    output logic             o_frame_done,
    input  logic             i_rd_start,
    output logic [PX_BW-1:0] o_rd_px,
    output logic             o_rd_valid,
    output logic             o_rd_last,
    input  logic             i_rd_ready,
    output logic             o_overflow
);

    localparam int N  = IMG_W * IMG_H;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_FULL    = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;

    logic [1:0]       state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [PX_BW-1:0] mem [N];
    logic             accept;
    logic             hs;

    assign o_in_ready = (state == S_COLLECT);
    assign accept     = o_in_ready && i_px_valid && !i_clr;
    assign hs         = o_rd_valid && i_rd_ready;

    // Buffer has no reset: its contents are meaningless until rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= i_px;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_COLLECT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_frame_done <= 1'b0;
            o_rd_px      <= '0;
            o_rd_valid   <= 1'b0;
            o_rd_last    <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_clr) begin
                state      <= S_COLLECT;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                o_rd_valid <= 1'b0;
                o_rd_last  <= 1'b0;
                o_overflow <= 1'b0;
            end else begin
                if (i_px_valid && state != S_COLLECT) begin
                    o_overflow <= 1'b1;
                end
                case (state)
                    S_COLLECT: begin
                        if (i_px_valid) begin
                            if (wr_ptr == LAST) begin
                                wr_ptr       <= '0;
                                state        <= S_FULL;
                                o_frame_done <= 1'b1;
                            end else begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                        end
                    end
                    S_FULL: begin
                        if (i_rd_start) begin
                            state      <= S_READ;
                            o_rd_px    <= mem[0];
                            o_rd_valid <= 1'b1;
                            o_rd_last  <= (LAST == '0);
                            rd_ptr     <= (LAST == '0) ? '0 : AW'(1);
                        end
                    end
                    S_READ: begin
                        if (hs) begin
                            if (o_rd_last) begin
                                o_rd_valid <= 1'b0;
                                o_rd_last  <= 1'b0;
                                rd_ptr     <= '0;
                                state      <= S_COLLECT;
                            end else begin
                                // rd_ptr is the index being loaded, so the
                                // last flag follows the loaded index.
                                o_rd_px   <= mem[rd_ptr];
                                o_rd_last <= (rd_ptr == LAST);
                                rd_ptr    <= (rd_ptr == LAST) ? '0
                                                              : rd_ptr + 1'b1;
                            end
                        end
                    end
                    default: state <= S_COLLECT;
                endcase
            end
        end
    end

endmodule
